// File: rtl/mips_boot_pkg.sv
// mips_boot_pkg: shared constants for the mips_single boot loader.
package mips_boot_pkg;

  // Loader states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_LEN  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;
  localparam logic [2:0] ST_HOLD = 3'd5;
  localparam logic [2:0] ST_RUN  = 3'd6;

  // Frame command bytes
  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_DMEM = 8'h02;
  localparam logic [7:0] CMD_GO   = 8'hFF;

  // Memory select encoding
  localparam logic MEM_SEL_I = 1'b0;
  localparam logic MEM_SEL_D = 1'b1;

endpackage

// File: rtl/mips_boot_loader_if.sv
// mips_boot_loader_if: byte-stream input and byte-wide memory write bus.
interface mips_boot_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  // Loader side: consumes the stream, drives the memory bus
  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_sel, mem_addr, mem_wdata
  );

  // Environment side: produces the stream, observes the memory bus
  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_sel, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_boot_hold_cnt.sv
// mips_boot_hold_cnt: countdown that times the CPU reset hold after GO.
module mips_boot_hold_cnt #(
  parameter int unsigned RST_HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired_c
);
  localparam int unsigned CNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load on GO, then step down once per cycle while holding
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(RST_HOLD - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/mips_boot_loader.sv
// mips_boot_loader: frame-based byte loader for the mips_single memories.
// Holds the CPU in reset until GO. Optional trailing checksum byte per load
// frame is enabled with the macro BOOT_CHECKSUM_EN.
module mips_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_boot_loader_if.master   bus,
  output logic                 cpu_rst,
  output logic                 load_err,
  output logic [LEN_W-1:0]     load_count
);
  localparam int unsigned ADDR_BYTES = ADDR_W / 8;
  localparam int unsigned LEN_BYTES  = LEN_W / 8;
  localparam int unsigned IDX_W      = 16;

`ifdef BOOT_CHECKSUM_EN
  localparam logic [2:0] ST_FRAME_END = ST_CSUM;
`else
  localparam logic [2:0] ST_FRAME_END = ST_IDLE;
`endif

  logic [2:0]        state_q,      state_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [LEN_W-1:0]  len_q,        len_d;
  logic [IDX_W-1:0]  idx_q,        idx_d;
  logic              mem_we_q,     mem_we_d;
  logic              mem_sel_q,    mem_sel_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [7:0]        mem_wdata_q,  mem_wdata_d;
  logic              cpu_rst_q,    cpu_rst_d;
  logic              load_err_q,   load_err_d;
  logic [LEN_W-1:0]  load_count_q, load_count_d;

  logic              in_ready_c;
  logic              accept_c;
  logic              go_ok_c;
  logic              hold_load_c;
  logic              hold_expired_c;
  logic [ADDR_W-1:0] addr_shift_c;
  logic [LEN_W-1:0]  len_shift_c;

  // Stream is accepted in every frame-parsing state, never in reset/HOLD/RUN
  assign in_ready_c = !rst && ((state_q == ST_IDLE) || (state_q == ST_ADDR) ||
                               (state_q == ST_LEN)  || (state_q == ST_DATA) ||
                               (state_q == ST_CSUM));
  assign accept_c   = bus.in_valid && in_ready_c;

  // Multi-byte fields arrive LSB first: new byte enters at the top
  assign addr_shift_c = (addr_q >> 8) | (ADDR_W'(bus.in_data) << (ADDR_W - 8));
  assign len_shift_c  = (len_q  >> 8) | (LEN_W'(bus.in_data)  << (LEN_W - 8));

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  assign go_ok_c = !load_err_q;

  // Running sum restarts on every byte taken in IDLE, accumulates through DATA
  always_comb begin
    csum_d = csum_q;
    if (accept_c) begin
      if (state_q == ST_IDLE) begin
        csum_d = bus.in_data;
      end else if (state_q != ST_CSUM) begin
        csum_d = csum_q + bus.in_data;
      end
    end
  end

  // Checksum register
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`else
  assign go_ok_c = 1'b1;
`endif

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    idx_d        = idx_q;
    mem_we_d     = 1'b0;
    mem_sel_d    = mem_sel_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rst_d    = cpu_rst_q;
    load_err_d   = load_err_q;
    load_count_d = load_count_q;
    hold_load_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if ((bus.in_data == CMD_IMEM) || (bus.in_data == CMD_DMEM)) begin
            mem_sel_d = (bus.in_data == CMD_DMEM) ? MEM_SEL_D : MEM_SEL_I;
            idx_d     = '0;
            state_d   = ST_ADDR;
          end else if (bus.in_data == CMD_GO) begin
            if (go_ok_c) begin
              hold_load_c = 1'b1;
              state_d     = ST_HOLD;
            end
          end else begin
            load_err_d = 1'b1;
          end
        end
      end

      ST_ADDR: begin
        if (accept_c) begin
          addr_d = addr_shift_c;
          if (idx_q == IDX_W'(ADDR_BYTES - 1)) begin
            idx_d   = '0;
            state_d = ST_LEN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ST_LEN: begin
        if (accept_c) begin
          len_d        = len_shift_c;
          load_count_d = '0;
          if (idx_q == IDX_W'(LEN_BYTES - 1)) begin
            idx_d   = '0;
            state_d = (len_shift_c == '0) ? ST_FRAME_END : ST_DATA;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (accept_c) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = addr_q;
          mem_wdata_d  = bus.in_data;
          addr_d       = addr_q + ADDR_W'(1);
          load_count_d = load_count_q + LEN_W'(1);
          if (load_count_d == len_q) begin
            state_d = ST_FRAME_END;
          end
        end
      end

      ST_CSUM: begin
`ifdef BOOT_CHECKSUM_EN
        if (accept_c) begin
          if (bus.in_data != csum_q) begin
            load_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_HOLD: begin
        if (hold_expired_c) begin
          cpu_rst_d = 1'b0;
          state_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= MEM_SEL_I;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rst_q    <= 1'b1;
      load_err_q   <= 1'b0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      mem_we_q     <= mem_we_d;
      mem_sel_q    <= mem_sel_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      load_err_q   <= load_err_d;
      load_count_q <= load_count_d;
    end
  end

  mips_boot_hold_cnt #(
    .RST_HOLD (RST_HOLD)
  ) u_hold_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load_c),
    .en        (state_q == ST_HOLD),
    .expired_c (hold_expired_c)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_sel   = mem_sel_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_rst       = cpu_rst_q;
  assign load_err      = load_err_q;
  assign load_count    = load_count_q;

endmodule

// File: doc/mips_boot_loader.md
Name: mips_boot_loader

Overview:
- Sits directly upstream of mips_single.
- Receives a byte-stream load image and writes it into the CPU's byte-wide, little-endian instruction and data memories.
- Holds the CPU in reset until a GO command arrives, then releases it after a fixed hold time.
- Gives the single-cycle core a synthesizable, frame-based load path that does not depend on simulation-only memory initialisation.

Parameters:
- ADDR_W, 32, width of the memory byte address
- LEN_W, 16, width of the payload length field; must be a multiple of 8
- RST_HOLD, 4, cycles cpu_rst stays high after GO is accepted; must be at least 1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte
- mem_we  out  1  one-cycle byte write strobe
- mem_sel  out  1  0 = instruction memory, 1 = data memory
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  byte to write
- cpu_rst  out  1  reset to mips_single, active-high
- load_err  out  1  sticky error flag
- load_count  out  LEN_W  payload bytes written in the current or last frame

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high. All outputs are registered except in_ready.
- Reset values: state=IDLE, cpu_rst=1, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, load_err=0, load_count=0.
- in_ready while rst=1: 0.
- in_ready otherwise: 1 in IDLE, ADDR, LEN, DATA and CSUM; 0 in HOLD and RUN.
- Byte acceptance: a byte is accepted on a clk edge with in_valid & in_ready. in_valid may drop between bytes with no effect.
- Frame format: CMD, ADDR (ADDR_W/8 bytes, LSB first), LEN (LEN_W/8 bytes, LSB first), LEN payload bytes, then CSUM only if enabled.
- CMD values:
  - 0x01: load instruction memory
  - 0x02: load data memory
  - 0xFF: GO
  - any other value: load_err <= 1, stay in IDLE, byte dropped
- States and transitions:
  - IDLE: accept CMD. 0x01/0x02 latch mem_sel and go to ADDR. 0xFF goes to HOLD.
  - ADDR: shift address bytes in LSB first; after the last one go to LEN.
  - LEN: shift length bytes in; clear load_count. If the length is 0, go to IDLE (or CSUM if enabled). Otherwise go to DATA.
  - DATA: each accepted byte produces, on the next cycle, mem_we=1 with the current address and the byte as mem_wdata. The address then increments modulo 2^ADDR_W (0xFFFFFFFF wraps to 0) and load_count increments. After the LEN-th byte go to IDLE (or CSUM).
  - HOLD: count down RST_HOLD cycles with cpu_rst=1, then set cpu_rst=0 and go to RUN.
  - RUN: terminal. Only rst leaves it; stream input is ignored.
- Write strobe: mem_we is high for exactly one cycle per payload byte and never outside DATA-generated writes. Back-to-back accepted bytes give back-to-back writes.
- Multiple frames: multiple load frames may precede GO. Later writes to the same address overwrite earlier ones.
- Reset mid-operation: rst in any state aborts the frame, discards partial address and length, re-asserts cpu_rst the same edge, and clears load_err. Memory contents already written are kept.
- load_err: sticky until rst. It does not block further frames or GO unless stated otherwise in Optional Feature.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined: each load frame ends with one CSUM byte, checked against the 8-bit modulo-256 sum of CMD, ADDR, LEN and payload bytes.
  - Mismatch sets load_err. While load_err=1, GO is refused: it is dropped, cpu_rst stays 1, and the state stays IDLE.
  - Writes are not rolled back.
- Undefined: no CSUM state. Frames end after the payload, and GO is always honoured.

Decomposition:
- Package mips_boot_pkg holds:
  - state enum: IDLE, ADDR, LEN, DATA, CSUM, HOLD, RUN
  - CMD_IMEM=8'h01, CMD_DMEM=8'h02, CMD_GO=8'hFF
  - MEM_SEL_I=1'b0, MEM_SEL_D=1'b1
- Keep in one module; the address and length shift-in is small.
- Optional sub-module: mips_boot_hold_cnt for the RST_HOLD countdown.

Test Plan:
- Reset check: rst high 2 cycles -> cpu_rst=1, in_ready=0, mem_we=0. After rst falls, in_ready=1 and no write occurs.
- Instruction load: 01, 00 00 00 00, 08 00, eight bytes 20 08 00 05 20 09 00 03 -> eight consecutive mem_we pulses, mem_sel=0, addresses 0..7, data in order, load_count=8.
- Data load with in_valid gaps: 02, 10 00 00 00, 04 00, AA BB CC DD with in_valid low 3 cycles between each byte -> writes at addresses 0x10..0x13, mem_sel=1, exactly 4 strobes.
- GO release: FF -> cpu_rst stays 1 for exactly 4 cycles, then 0, in_ready=0. Further bytes 01 ... produce no writes.
- Errors: 0x55 in IDLE -> load_err=1 with no state change. Length 0 frame -> no writes. Address FF FF FF FF with length 2 -> writes at 0xFFFFFFFF then 0x00000000.
- Reset mid-DATA after 3 of 8 bytes -> no further strobes, cpu_rst=1, load_err=0. A fresh frame then loads correctly.
- With BOOT_CHECKSUM_EN: a bad CSUM makes load_err=1 and the following FF leaves cpu_rst=1. A good CSUM followed by FF releases cpu_rst after 4 cycles.
